// File: rtl/element_delay_sequencer.sv
// Requester side of the increment-term calculator handshake: emits one accumulated,
// saturated delay per array element on a valid/accept stream, starting from r_0.
module element_delay_sequencer #(
    parameter int DW_INTEGER   = 18,
    parameter int DW_FRACTION  = 6,
    parameter int DW_INPUT     = 8,
    parameter int NUM_ELEMENTS = 32,
    parameter int IDX_W        = 5,
    parameter int TIMEOUT      = 1023,
    localparam int W           = DW_INTEGER + DW_FRACTION + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [DW_INPUT-1:0] r0_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                calc_initiate_o,
    output logic                calc_ack_o,
    input  logic [W-1:0]        calc_term_i,
    input  logic                calc_ready_i,
    output logic [W-1:0]        delay_out_o,
    output logic [IDX_W-1:0]    delay_idx_o,
    output logic                delay_valid_o,
    input  logic                delay_accept_i
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EMIT = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ELEMENTS - 1);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [W-1:0]     DELAY_MAX  = {1'b0, {(W-1){1'b1}}};

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             init_q, init_d;
    logic             ack_q, ack_d;
    logic             valid_q, valid_d;

    logic [W:0]       sum;
    logic [W-1:0]     satSum;

    // acc is never negative, so one extra bit holds the signed sum without overflow.
    always_comb begin
        sum = {1'b0, acc_q} + {calc_term_i[W-1], calc_term_i};
        if (sum[W]) begin
            satSum = '0;
        end else if (sum[W-1]) begin
            satSum = DELAY_MAX;
        end else begin
            satSum = sum[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d   = W'({r0_i, {DW_FRACTION{1'b0}}});
                    idx_d   = '0;
                    timer_d = '0;
                    err_d   = 1'b0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (delay_accept_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = '0;
                        // Skip REQ when the previous term is already retired.
                        state_d = calc_ready_i ? S_REQ : S_WAIT;
                    end
                end
            end
            S_REQ: begin
                if (!calc_ready_i) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (calc_ready_i) begin
                    acc_d   = satSum;
                    timer_d = '0;
                    state_d = S_ACK;
                end else if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ACK:   state_d = S_EMIT;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are registered from the upcoming state so they line up with it.
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_EMIT);
        init_d  = (state_d == S_WAIT) && (state_q != S_WAIT);
        ack_d   = (state_d == S_ACK);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            init_q  <= init_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign calc_initiate_o = init_q;
    assign calc_ack_o      = ack_q;
    assign delay_out_o     = acc_q;
    assign delay_idx_o     = idx_q;
    assign delay_valid_o   = valid_q;

endmodule
